// File: rtl/lc3_controller.sv
// LC3 instruction-sequencing FSM: Fetch/Decode/Execute plus memory and register-update phases.
// Latency: one state per cycle; memory states hold until mem_ready, retire pulse one cycle after entering Fetch.
// Backpressure: mem_ready stalls memory states; a watchdog forces Halt after MAX_WAIT idle cycles.
module lc3_controller #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       C_Control,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             halted,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [3:0] S_FETCH   = 4'b0001;
    localparam logic [3:0] S_DECODE  = 4'b0010;
    localparam logic [3:0] S_EXECUTE = 4'b0011;
    localparam logic [3:0] S_RD_IND  = 4'b0100;
    localparam logic [3:0] S_RD_MEM  = 4'b0101;
    localparam logic [3:0] S_WR_MEM  = 4'b0111;
    localparam logic [3:0] S_UPD_RF  = 4'b1001;
    localparam logic [3:0] S_HALT    = 4'b1111;

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [3:0]        next_state;
    logic [1:0]        cls_q;
    logic              ind_load_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_state;
    logic              retire_now;
    logic [3:0]        stall_state;

    // A memory state that is still waiting either holds or, on its last allowed cycle, gives up.
    assign mem_state   = mem_rd | mem_wr;
    assign stall_state = (wait_cnt == WAIT_LAST) ? S_HALT : state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_FETCH;
            cls_q         <= 2'b00;
            ind_load_q    <= 1'b0;
            wait_cnt      <= '0;
            halted        <= 1'b0;
            instr_retired <= 1'b0;
            retire_count  <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                cls_q <= C_Control[5:4];
            end
            if (state == S_EXECUTE) begin
                ind_load_q <= (C_Control[3:0] == 4'b0001);
            end
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (mem_state && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            halted        <= (next_state == S_HALT);
            instr_retired <= retire_now;
            if (retire_now) begin
                retire_count <= retire_count + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = S_HALT;
        case (state)
            S_FETCH:   next_state = mem_ready ? S_DECODE : stall_state;
            S_DECODE:  next_state = S_EXECUTE;
            S_EXECUTE: begin
                case ({cls_q, C_Control[3:0]})
                    6'b00_0000: next_state = S_UPD_RF;
                    6'b01_0000: next_state = S_FETCH;
                    6'b01_1000: next_state = S_UPD_RF;
                    6'b10_0010: next_state = S_RD_MEM;
                    6'b10_0001: next_state = S_RD_IND;
                    6'b10_0110: next_state = S_UPD_RF;
                    6'b10_0100: next_state = S_WR_MEM;
                    6'b10_0000: next_state = S_RD_IND;
                    default:    next_state = S_HALT;
                endcase
            end
            S_RD_IND:  next_state = mem_ready ? (ind_load_q ? S_RD_MEM : S_WR_MEM) : stall_state;
            S_RD_MEM:  next_state = mem_ready ? S_UPD_RF : stall_state;
            S_WR_MEM:  next_state = mem_ready ? S_FETCH : stall_state;
            S_UPD_RF:  next_state = S_FETCH;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_HALT;
        endcase
    end

    // Only a completing state can move into Fetch; Fetch itself merely holds.
    assign retire_now = (next_state == S_FETCH) && (state != S_FETCH);

    always_comb begin
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        case (state)
            S_FETCH, S_RD_IND, S_RD_MEM: mem_rd = 1'b1;
            S_WR_MEM:                    mem_wr = 1'b1;
            default:                     ;
        endcase
    end

endmodule

// File: tb/tb_lc3_controller.sv
// Directed bench for lc3_controller: per-cycle expected outputs queued as stimulus is driven.
// Latency: outputs compared at the falling edge of the cycle they belong to.
// Backpressure: mem_ready driven per cycle to exercise stalls and the watchdog.
module tb_lc3_controller;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 2;

    localparam logic [3:0] S_F  = 4'b0001;
    localparam logic [3:0] S_D  = 4'b0010;
    localparam logic [3:0] S_E  = 4'b0011;
    localparam logic [3:0] S_RI = 4'b0100;
    localparam logic [3:0] S_RM = 4'b0101;
    localparam logic [3:0] S_WM = 4'b0111;
    localparam logic [3:0] S_U  = 4'b1001;
    localparam logic [3:0] S_H  = 4'b1111;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       c_control = 6'b0;
    logic             mem_ready = 1'b0;
    logic [3:0]       state;
    logic             mem_rd;
    logic             mem_wr;
    logic             halted;
    logic             instr_retired;
    logic [CNT_W-1:0] retire_count;

    always #5 clock = ~clock;

    lc3_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .C_Control     (c_control),
        .mem_ready     (mem_ready),
        .state         (state),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .halted        (halted),
        .instr_retired (instr_retired),
        .retire_count  (retire_count)
    );

    typedef struct packed {
        logic [3:0]       st;
        logic             rd;
        logic             wr;
        logic             hl;
        logic             ret;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    string            tag_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic compare_head();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = tag_q.pop_front();
        chk({t, ".state"}, {28'b0, state}, {28'b0, e.st});
        chk({t, ".mem_rd"}, {31'b0, mem_rd}, {31'b0, e.rd});
        chk({t, ".mem_wr"}, {31'b0, mem_wr}, {31'b0, e.wr});
        chk({t, ".halted"}, {31'b0, halted}, {31'b0, e.hl});
        chk({t, ".retired"}, {31'b0, instr_retired}, {31'b0, e.ret});
        chk({t, ".count"}, 32'(retire_count), 32'(e.cnt));
    endtask

    // One clock cycle: drive mem_ready, queue what this cycle must show, compare at the falling edge.
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st, input logic ret);
        exp_t e;
        mem_ready = rdy;
        if (ret) model_cnt = model_cnt + 1'b1;
        e.st  = st;
        e.rd  = (st == S_F) || (st == S_RI) || (st == S_RM);
        e.wr  = (st == S_WM);
        e.hl  = (st == S_H);
        e.ret = ret;
        e.cnt = model_cnt;
        sb.push_back(e);
        tag_q.push_back(tag);
        @(negedge clock);
        compare_head();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clock);
        #1;
        model_cnt = '0;
        cyc("rst", 1'b0, S_F, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ADD with mem_ready tied high
        do_reset();
        c_control = 6'b00_0000;
        cyc("add_f", 1'b1, S_F, 1'b0);
        cyc("add_d", 1'b1, S_D, 1'b0);
        cyc("add_e", 1'b1, S_E, 1'b0);
        cyc("add_u", 1'b1, S_U, 1'b0);
        cyc("add_ret", 1'b1, S_F, 1'b1);

        // LDI with three stall cycles in each memory state
        do_reset();
        c_control = 6'b10_0001;
        cyc("ldi_f", 1'b1, S_F, 1'b0);
        cyc("ldi_d", 1'b0, S_D, 1'b0);
        cyc("ldi_e", 1'b0, S_E, 1'b0);
        for (int i = 0; i < 3; i++) cyc("ldi_ri_wait", 1'b0, S_RI, 1'b0);
        cyc("ldi_ri_go", 1'b1, S_RI, 1'b0);
        for (int i = 0; i < 3; i++) cyc("ldi_rm_wait", 1'b0, S_RM, 1'b0);
        cyc("ldi_rm_go", 1'b1, S_RM, 1'b0);
        cyc("ldi_u", 1'b0, S_U, 1'b0);
        cyc("ldi_ret", 1'b1, S_F, 1'b1);

        // STI followed by ST
        do_reset();
        c_control = 6'b10_0000;
        cyc("sti_f", 1'b1, S_F, 1'b0);
        cyc("sti_d", 1'b1, S_D, 1'b0);
        cyc("sti_e", 1'b1, S_E, 1'b0);
        cyc("sti_ri", 1'b1, S_RI, 1'b0);
        cyc("sti_wm", 1'b1, S_WM, 1'b0);
        cyc("sti_ret", 1'b1, S_F, 1'b1);
        c_control = 6'b10_0100;
        cyc("st_d", 1'b1, S_D, 1'b0);
        cyc("st_e", 1'b1, S_E, 1'b0);
        cyc("st_wm_wait", 1'b0, S_WM, 1'b0);
        cyc("st_wm", 1'b1, S_WM, 1'b0);
        cyc("st_ret", 1'b1, S_F, 1'b1);

        // BR, JSR, then a bad opcode that must halt for good
        do_reset();
        c_control = 6'b01_0000;
        cyc("br_f", 1'b1, S_F, 1'b0);
        cyc("br_d", 1'b1, S_D, 1'b0);
        cyc("br_e", 1'b1, S_E, 1'b0);
        cyc("br_ret", 1'b1, S_F, 1'b1);
        c_control = 6'b01_1000;
        cyc("jsr_d", 1'b1, S_D, 1'b0);
        cyc("jsr_e", 1'b1, S_E, 1'b0);
        cyc("jsr_u", 1'b1, S_U, 1'b0);
        cyc("jsr_ret", 1'b1, S_F, 1'b1);
        c_control = 6'b11_1111;
        cyc("bad_d", 1'b1, S_D, 1'b0);
        cyc("bad_e", 1'b1, S_E, 1'b0);
        for (int i = 0; i < 20; i++) cyc("bad_halt", 1'(i % 2), S_H, 1'b0);

        // Watchdog: four waiting cycles in Fetch halt the FSM
        do_reset();
        for (int i = 0; i < MAX_WAIT; i++) cyc("wd_wait", 1'b0, S_F, 1'b0);
        cyc("wd_halt", 1'b1, S_H, 1'b0);
        cyc("wd_stay", 1'b1, S_H, 1'b0);

        // Watchdog: ready arriving on the last allowed cycle wins
        do_reset();
        c_control = 6'b00_0000;
        for (int i = 0; i < MAX_WAIT - 1; i++) cyc("wd2_wait", 1'b0, S_F, 1'b0);
        cyc("wd2_go", 1'b1, S_F, 1'b0);
        cyc("wd2_d", 1'b0, S_D, 1'b0);
        cyc("wd2_e", 1'b0, S_E, 1'b0);
        cyc("wd2_u", 1'b0, S_U, 1'b0);
        cyc("wd2_ret", 1'b1, S_F, 1'b1);

        // Counter wrap over five branches, then reset in the middle of ReadMem
        do_reset();
        c_control = 6'b01_0000;
        cyc("wrap_f", 1'b1, S_F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc("wrap_d", 1'b1, S_D, 1'b0);
            cyc("wrap_e", 1'b1, S_E, 1'b0);
            cyc("wrap_ret", 1'b1, S_F, 1'b1);
        end
        c_control = 6'b10_0010;
        cyc("ld_d", 1'b1, S_D, 1'b0);
        cyc("ld_e", 1'b1, S_E, 1'b0);
        cyc("ld_rm_wait", 1'b0, S_RM, 1'b0);
        reset = 1'b1;
        cyc("ld_rm_rst", 1'b1, S_RM, 1'b0);
        model_cnt = '0;
        cyc("ld_abort", 1'b1, S_F, 1'b0);
        reset = 1'b0;
        cyc("ld_after", 1'b0, S_F, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_controller.md
Name: lc3_controller

Overview:
- Instruction-sequencing FSM for the LC3 datapath; drives the 4-bit `state` bus that the Decode, Fetch, Execute, MemAccess and Writeback stages consume.
- Consumes the 6-bit `C_Control` word that Decode produces.
- Runs each instruction through its memory and register-update phases, waiting on a memory ready handshake guarded by a watchdog.
- Counts retired instructions.

Parameters:
- MAX_WAIT, 255, cycles a memory state may wait for `mem_ready` before the FSM declares a fault and halts.
- CNT_W, 16, width of `retire_count`.

Ports:
- clock  input  1  global system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- C_Control  input  6  from Decode; [5:4] instruction class, [3:0] sub-operation.
- mem_ready  input  1  memory completes the current access on this cycle.
- state  output  4  registered system state, broadcast to all stages.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request.
- halted  output  1  FSM in Halt.
- instr_retired  output  1  one-cycle pulse per completed instruction.
- retire_count  output  CNT_W  retired-instruction counter.

Behaviour:
- State encoding:
  - Fetch 0001, Decode 0010, Execute 0011.
  - ReadIndirect 0100, ReadMem 0101, WriteMem 0111.
  - UpdateRegFile 1001, Halt 1111.
  - All other codes are unused; if one is ever reached, the next state is Halt.
- Reset (sampled at posedge), takes priority over everything:
  - state=0001, halted=0, instr_retired=0, retire_count=0.
  - Internal class register=00, wait counter=0.
  - Reset mid-access abandons the access; no pulse or count for the aborted instruction.
- Class latch: at the posedge leaving Decode, latch C_Control[5:4].
  - 00 = arithmetic, 01 = goto, 10 = load/store, 11 = bad.
- Sub-operation: C_Control[3:0] is sampled combinationally in Execute. It is valid from Execute onward because IR loads at the end of Decode.
- Transitions:
  - Fetch -> Decode on mem_ready.
  - Decode -> Execute unconditionally.
  - Execute, by class and sub-operation:
    - arith, sub 0000 -> UpdateRegFile.
    - goto, sub 0000 (BR/JMP) -> Fetch; retires.
    - goto, sub 1000 (JSR/JSRR) -> UpdateRegFile.
    - ld/st, sub 0010 (LD/LDR) -> ReadMem.
    - ld/st, sub 0001 (LDI) -> ReadIndirect.
    - ld/st, sub 0110 (LEA) -> UpdateRegFile.
    - ld/st, sub 0100 (ST/STR) -> WriteMem.
    - ld/st, sub 0000 (STI) -> ReadIndirect.
    - class 11, sub 1111, or any other combination -> Halt.
  - ReadIndirect -> on mem_ready: ReadMem for LDI, WriteMem for STI. The LDI/STI choice uses a flag latched in Execute.
  - ReadMem -> UpdateRegFile on mem_ready.
  - WriteMem -> Fetch on mem_ready; retires.
  - UpdateRegFile -> Fetch unconditionally; retires.
  - Halt -> Halt until reset.
- Memory strobes:
  - mem_rd = 1 exactly in Fetch, ReadIndirect and ReadMem.
  - mem_wr = 1 exactly in WriteMem.
  - Both are decoded from the registered state; both are 0 in Halt.
  - mem_ready is ignored in all other states.
- Watchdog:
  - Wait counter clears on every state change and increments each cycle spent in a memory state with mem_ready=0.
  - When the counter reaches MAX_WAIT with mem_ready still 0, next state is Halt.
  - mem_ready=1 on that same cycle wins: the normal transition is taken.
- Retirement:
  - On every posedge that enters Fetch from a completing state, the next cycle has instr_retired=1 and retire_count increments by 1.
  - retire_count wraps from all-ones to 0. The pulse is never asserted after reset or when entering Halt.
- Halt: halted=1 registered, asserted the same cycle state reads 1111.

Test Plan:
- ADD, mem_ready tied 1:
  - Reset 2 cycles, then C_Control[5:4]=00 at Decode and [3:0]=0000.
  - state sequence 0001,0010,0011,1001,0001; instr_retired high one cycle; retire_count=1.
- LDI with memory latency:
  - C_Control=10/0001; mem_ready low 3 cycles in each memory state.
  - state 0001,0010,0011,0100(x4),0101(x4),1001,0001; mem_rd=1 only in 0001/0100/0101.
- STI then ST:
  - STI (10/0000) path is 0011->0100->0111->0001 with mem_wr=1 only in 0111.
  - ST (10/0100) path is 0011->0111->0001; retire_count=2.
- BR and JSR:
  - 01/0000: 0011->0001 directly.
  - 01/1000: 0011->1001->0001.
  - Bad opcode 11/1111: state=1111, halted=1; stays 1111 for 20 cycles with mem_ready toggling.
- Watchdog boundary, MAX_WAIT=4:
  - mem_ready never asserted in Fetch: state=1111 after 4 waiting cycles.
  - Repeat with mem_ready=1 on the 4th wait cycle: Decode is entered, no halt.
- Reset mid-ReadMem and counter wrap:
  - Assert reset while state=0101: next state 0001, retire_count=0, no pulse.
  - With CNT_W=2, retire 5 instructions: retire_count reads 1,2,3,0,1.
